// File: rtl/keypad_entry_ctrl_if.sv
// Completed-entry handshake between the keypad entry controller and its consumer.
// The controller drives the entry fields and valid; the consumer returns ack.
interface keypad_entry_ctrl_if;
    logic [13:0] out_value;
    logic [2:0]  out_cmd;
    logic [2:0]  out_ndigits;
    logic        out_valid;
    logic        out_ack;

    modport master (
        output out_value,
        output out_cmd,
        output out_ndigits,
        output out_valid,
        input  out_ack
    );

    modport slave (
        input  out_value,
        input  out_cmd,
        input  out_ndigits,
        input  out_valid,
        output out_ack
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: polls the 4x4 scanner, assembles up to MAX_DIGITS decimal
// digits plus an optional command key, and hands the finished entry to a consumer.
module keypad_entry_ctrl #(
    parameter int MAX_DIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            kp_dataout,
    output logic                   kp_a0,
    output logic                   kp_readyclr,
    output logic [15:0]            entry_bcd,
    output logic                   err,
    keypad_entry_ctrl_if.master    entry
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    typedef enum logic [2:0] {
        ST_POLL = 3'd0,
        ST_READ = 3'd1,
        ST_CLR  = 3'd2,
        ST_EXEC = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  key_r;
    logic [3:0]  key_s;
    logic [13:0] value_r;
    logic [13:0] value_s;
    logic [2:0]  count_r;
    logic [2:0]  count_s;
    logic [2:0]  cmd_r;
    logic [2:0]  cmd_s;
    logic [15:0] bcd_r;
    logic [15:0] bcd_s;
    logic        err_r;
    logic        err_s;
    logic        a0_r;
    logic        a0_s;
    logic        readyclr_r;
    logic        readyclr_s;
    logic [13:0] out_value_r;
    logic [13:0] out_value_s;
    logic [2:0]  out_cmd_r;
    logic [2:0]  out_cmd_s;
    logic [2:0]  out_nd_r;
    logic [2:0]  out_nd_s;
    logic        out_valid_r;
    logic        out_valid_s;

    // The scanner only defines the low nibble of its read bus.
    logic        unused_bus_s;
    assign unused_bus_s = ^kp_dataout[15:4];

    function automatic logic [13:0] mac10(input logic [13:0] acc, input logic [3:0] d);
        return (acc * 14'd10) + {10'd0, d};
    endfunction

    // Keys 0xA..0xD map onto command codes 1..4.
    function automatic logic [2:0] cmd_of(input logic [3:0] k);
        logic [3:0] t;
        t = k - 4'h9;
        return t[2:0];
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_s     = state_r;
        key_s       = key_r;
        value_s     = value_r;
        count_s     = count_r;
        cmd_s       = cmd_r;
        bcd_s       = bcd_r;
        err_s       = 1'b0;
        out_value_s = out_value_r;
        out_cmd_s   = out_cmd_r;
        out_nd_s    = out_nd_r;
        out_valid_s = out_valid_r;

        case (state_r)
            ST_POLL: begin
                if (kp_dataout[0]) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_POLL;
                end
            end
            ST_READ: begin
                key_s   = kp_dataout[3:0];
                state_s = ST_CLR;
            end
            ST_CLR: begin
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                state_s = ST_POLL;
                if (key_r <= 4'h9) begin
                    if (count_r < MAX_CNT) begin
                        value_s = mac10(value_r, key_r);
                        bcd_s   = {bcd_r[11:0], key_r};
                        count_s = count_r + 3'd1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (key_r <= 4'hD) begin
                    cmd_s = cmd_of(key_r);
                end else if (key_r == 4'hE) begin
                    value_s = 14'd0;
                    bcd_s   = 16'd0;
                    count_s = 3'd0;
                    cmd_s   = 3'd0;
                end else begin
                    if (count_r != 3'd0) begin
                        out_value_s = value_r;
                        out_cmd_s   = cmd_r;
                        out_nd_s    = count_r;
                        out_valid_s = 1'b1;
                        state_s     = ST_HOLD;
                    end else begin
                        err_s = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // The displayed digits stay up until the consumer takes the entry.
                if (entry.out_ack) begin
                    out_valid_s = 1'b0;
                    value_s     = 14'd0;
                    bcd_s       = 16'd0;
                    count_s     = 3'd0;
                    cmd_s       = 3'd0;
                    state_s     = ST_POLL;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_POLL;
            end
        endcase

        a0_s       = (state_s != ST_READ);
        readyclr_s = (state_s == ST_CLR);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_POLL;
            key_r       <= 4'd0;
            value_r     <= 14'd0;
            count_r     <= 3'd0;
            cmd_r       <= 3'd0;
            bcd_r       <= 16'd0;
            err_r       <= 1'b0;
            a0_r        <= 1'b1;
            readyclr_r  <= 1'b0;
            out_value_r <= 14'd0;
            out_cmd_r   <= 3'd0;
            out_nd_r    <= 3'd0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            key_r       <= key_s;
            value_r     <= value_s;
            count_r     <= count_s;
            cmd_r       <= cmd_s;
            bcd_r       <= bcd_s;
            err_r       <= err_s;
            a0_r        <= a0_s;
            readyclr_r  <= readyclr_s;
            out_value_r <= out_value_s;
            out_cmd_r   <= out_cmd_s;
            out_nd_r    <= out_nd_s;
            out_valid_r <= out_valid_s;
        end
    end

    assign kp_a0             = a0_r;
    assign kp_readyclr       = readyclr_r;
    assign entry_bcd         = bcd_r;
    assign err               = err_r;
    assign entry.out_value   = out_value_r;
    assign entry.out_cmd     = out_cmd_r;
    assign entry.out_ndigits = out_nd_r;
    assign entry.out_valid   = out_valid_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: a scanner model, a digit-list reference model compared
// every cycle, directed literal checks and a randomized key/ack/reset run.
module tb_keypad_entry_ctrl;
    localparam int MAX_DIGITS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] kp_dataout;
    logic        kp_a0;
    logic        kp_readyclr;
    logic [15:0] entry_bcd;
    logic        err;

    keypad_entry_ctrl_if ent();

    keypad_entry_ctrl #(.MAX_DIGITS(MAX_DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .kp_dataout (kp_dataout),
        .kp_a0      (kp_a0),
        .kp_readyclr(kp_readyclr),
        .entry_bcd  (entry_bcd),
        .err        (err),
        .entry      (ent)
    );

    always #5 clk = ~clk;

    // Scanner: a new press wins over a simultaneous clear; reset does not touch it.
    logic       sc_ready = 1'b0;
    logic [3:0] sc_key = 4'd0;
    logic       press_req = 1'b0;
    logic [3:0] press_key = 4'd0;
    always @(posedge clk) begin
        if (press_req) begin
            sc_key   <= press_key;
            sc_ready <= 1'b1;
        end else if (kp_readyclr) begin
            sc_ready <= 1'b0;
        end
    end
    assign kp_dataout = kp_a0 ? {15'd0, sc_ready} : {12'd0, sc_key};

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the entry is a list of digits; timing counts cycles since ready seen.
    int  since = 0;
    bit  m_hold = 1'b0;
    int  digits[$];
    int  m_cmd = 0;
    int  m_key = 0;
    int  m_oval = 0;
    int  m_ocmd = 0;
    int  m_ond = 0;
    bit  m_valid = 1'b0;
    bit  m_err = 1'b0;

    logic        exp_a0 = 1'b1;
    logic        exp_clr = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [13:0] exp_value = 14'd0;
    logic [2:0]  exp_cmd = 3'd0;
    logic [2:0]  exp_nd = 3'd0;
    logic [15:0] exp_bcd = 16'd0;

    function automatic int q_value();
        int v = 0;
        foreach (digits[i]) v = v * 10 + digits[i];
        return v;
    endfunction

    function automatic logic [15:0] q_bcd();
        logic [15:0] b = 16'd0;
        foreach (digits[i]) b = {b[11:0], 4'(digits[i])};
        return b;
    endfunction

    task model_step(input bit r, input bit a);
        m_err = 1'b0;
        if (r) begin
            since = 0; m_hold = 1'b0; digits.delete(); m_cmd = 0;
            m_oval = 0; m_ocmd = 0; m_ond = 0; m_valid = 1'b0;
        end else if (m_hold) begin
            if (a) begin
                m_hold = 1'b0; m_valid = 1'b0; digits.delete(); m_cmd = 0;
            end
        end else if (since == 0) begin
            if (sc_ready) since = 1;
        end else if (since == 1) begin
            m_key = int'(sc_key);
            since = 2;
        end else if (since == 2) begin
            since = 3;
        end else begin
            since = 0;
            if (m_key <= 9) begin
                if (digits.size() < MAX_DIGITS) digits.push_back(m_key);
                else m_err = 1'b1;
            end else if (m_key <= 13) begin
                m_cmd = m_key - 9;
            end else if (m_key == 14) begin
                digits.delete(); m_cmd = 0;
            end else if (digits.size() >= 1) begin
                m_oval = q_value(); m_ocmd = m_cmd; m_ond = digits.size();
                m_valid = 1'b1; m_hold = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task publish();
        exp_a0    = (since != 1);
        exp_clr   = (since == 2);
        exp_valid = m_valid;
        exp_err   = m_err;
        exp_value = 14'(m_oval);
        exp_cmd   = 3'(m_ocmd);
        exp_nd    = 3'(m_ond);
        exp_bcd   = q_bcd();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("kp_a0",       16'(kp_a0),           16'(exp_a0));
            chk("kp_readyclr", 16'(kp_readyclr),     16'(exp_clr));
            chk("out_valid",   16'(ent.out_valid),   16'(exp_valid));
            chk("out_value",   16'(ent.out_value),   16'(exp_value));
            chk("out_cmd",     16'(ent.out_cmd),     16'(exp_cmd));
            chk("out_ndigits", 16'(ent.out_ndigits), 16'(exp_nd));
            chk("entry_bcd",   entry_bcd,            exp_bcd);
            chk("err",         16'(err),             16'(exp_err));
        end
    end

    // One clock: inputs at the falling edge, model advanced to the post-edge view.
    task automatic step(input bit p, input logic [3:0] k, input bit a, input bit r);
        @(negedge clk);
        press_req = p; press_key = k; ent.out_ack = a; rst = r;
        model_step(r, a);
        @(posedge clk);
        publish();
        #1;
    endtask

    int kin_err_cnt, kin_err_at, kin_a0_cnt, kin_a0_at, kin_clr_cnt, kin_clr_at;

    task automatic key_in(input logic [3:0] k);
        kin_err_cnt = 0; kin_err_at = -1; kin_a0_cnt = 0; kin_a0_at = -1;
        kin_clr_cnt = 0; kin_clr_at = -1;
        step(1'b1, k, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0, 1'b0, 1'b0);
            if (err === 1'b1) begin kin_err_cnt++; if (kin_err_at < 0) kin_err_at = i; end
            if (kp_a0 === 1'b0) begin kin_a0_cnt++; if (kin_a0_at < 0) kin_a0_at = i; end
            if (kp_readyclr === 1'b1) begin kin_clr_cnt++; if (kin_clr_at < 0) kin_clr_at = i; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        step(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    int bad;

    initial begin
        rst = 1'b1;
        ent.out_ack = 1'b0;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("rst_a0",    16'(kp_a0),         16'd1);
        chk("rst_valid", 16'(ent.out_valid), 16'd0);
        chk("rst_bcd",   entry_bcd,          16'd0);
        chk("rst_clr",   16'(kp_readyclr),   16'd0);

        // 1,2,3,# with single-key timing taken from the first key
        key_in(4'h1);
        chk("t_a0_cnt",  16'(kin_a0_cnt),  16'd1);
        chk("t_a0_at",   16'(kin_a0_at),   16'd0);
        chk("t_clr_cnt", 16'(kin_clr_cnt), 16'd1);
        chk("t_clr_at",  16'(kin_clr_at),  16'd1);
        key_in(4'h2); key_in(4'h3); key_in(4'hF);
        chk("s1_valid", 16'(ent.out_valid),   16'd1);
        chk("s1_value", 16'(ent.out_value),   16'd123);
        chk("s1_nd",    16'(ent.out_ndigits), 16'd3);
        chk("s1_cmd",   16'(ent.out_cmd),     16'd0);
        chk("s1_bcd",   entry_bcd,            16'h0123);
        ack();
        chk("s1_ack_valid", 16'(ent.out_valid), 16'd0);
        chk("s1_ack_bcd",   entry_bcd,          16'h0000);
        idle(1);

        // overflow digit
        key_in(4'h9); key_in(4'h9); key_in(4'h9); key_in(4'h9);
        key_in(4'h5);
        chk("s2_err_cnt", 16'(kin_err_cnt), 16'd1);
        chk("s2_err_at",  16'(kin_err_at),  16'd3);
        chk("s2_bcd",     entry_bcd,        16'h9999);
        key_in(4'hF);
        chk("s2_value", 16'(ent.out_value),   16'd9999);
        chk("s2_nd",    16'(ent.out_ndigits), 16'd4);
        ack(); idle(1);

        // commands, last one wins
        key_in(4'h4); key_in(4'hB); key_in(4'h7); key_in(4'hC); key_in(4'hF);
        chk("s3_value", 16'(ent.out_value),   16'd47);
        chk("s3_cmd",   16'(ent.out_cmd),     16'd3);
        chk("s3_nd",    16'(ent.out_ndigits), 16'd2);
        ack(); idle(1);

        // clear then empty submit
        key_in(4'h5); key_in(4'hE); key_in(4'hF);
        chk("s4_err",   16'(kin_err_cnt),   16'd1);
        chk("s4_valid", 16'(ent.out_valid), 16'd0);
        key_in(4'h8); key_in(4'hF);
        chk("s4_value", 16'(ent.out_value), 16'd8);
        ack(); idle(1);

        // long hold with a press latched in the scanner
        key_in(4'h1); key_in(4'h2); key_in(4'hF);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(i == 10, 4'h7, 1'b0, 1'b0);
            if (ent.out_valid !== 1'b1 || ent.out_value !== 14'd12 || kp_a0 !== 1'b1) bad++;
        end
        chk("hold_stable", 16'(bad), 16'd0);
        ack(); idle(6);
        chk("hold_pending", entry_bcd, 16'h0007);
        key_in(4'hE);

        // reset while reading
        key_in(4'h2);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        idle(1);
        chk("rr_in_read", 16'(kp_a0), 16'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("rr_a0",  16'(kp_a0),   16'd1);
        chk("rr_bcd", entry_bcd,    16'h0000);
        idle(6);
        chk("rr_reread", entry_bcd, 16'h0003);
        key_in(4'hE);

        // reset while holding
        key_in(4'h4); key_in(4'hF);
        step(1'b1, 4'h6, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("rh_valid", 16'(ent.out_valid),   16'd0);
        chk("rh_value", 16'(ent.out_value),   16'd0);
        chk("rh_nd",    16'(ent.out_ndigits), 16'd0);
        chk("rh_bcd",   entry_bcd,            16'h0000);
        idle(6);
        chk("rh_reread", entry_bcd, 16'h0006);
        key_in(4'hE);

        // randomized keys, acks and occasional resets
        for (int i = 0; i < 3000; i++) begin
            int rr, kr;
            logic [3:0] k;
            rr = $urandom_range(0, 199);
            kr = $urandom_range(0, 9);
            if (kr < 6)       k = 4'($urandom_range(0, 9));
            else if (kr == 6) k = 4'($urandom_range(10, 13));
            else if (kr == 7) k = 4'hE;
            else              k = 4'hF;
            step(rr < 40, k, ($urandom_range(0, 99) < 15), rr == 199);
        end
        step(1'b0, 4'd0, 1'b1, 1'b0);
        idle(8);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller for the memory-mapped 4x4 keypad scanner. It polls the scanner's ready flag, reads the key code, and clears ready. It assembles decimal digits into a number of up to 4 digits with an optional command key, then presents the completed entry to the downstream consumer (CPU-side register or display logic) over a valid/ack handshake. It also drives a live BCD mirror of the digits typed so far, for the seven-segment display.

## Interface
Parameters:
- MAX_DIGITS, 4, maximum digits accepted per entry (1..4).

Ports:
- clk  in  1  system clock, same clock as the keypad scanner.
- rst  in  1  synchronous, active-high reset.
- kp_dataout  in  16  scanner read bus; when kp_a0=0, bits [3:0] are the key code; when kp_a0=1, bit [0] is ready.
- kp_a0  out  1  scanner register select (0 = data, 1 = status).
- kp_readyclr  out  1  one-cycle clear of the scanner ready flag.
- out_value  out  14  binary value of the submitted entry (0..9999).
- out_cmd  out  3  command of the submitted entry: 0 = none, 1..4 = A..D.
- out_ndigits  out  3  digit count of the submitted entry (1..MAX_DIGITS).
- out_valid  out  1  submitted entry available; held until acknowledged.
- out_ack  in  1  consumer accepts the entry; sampled only while out_valid=1.
- entry_bcd  out  16  digits typed so far, BCD, right-aligned (most recent digit in [3:0]).
- err  out  1  one-cycle pulse on a rejected key.

## Operation
- Key codes: 0x0-0x9 are digits. 0xA-0xD are command keys A-D. 0xE (`*`) clears the entry. 0xF (`#`) submits the entry.
- State machine: POLL -> READ -> CLR -> EXEC -> (POLL | HOLD).
  - POLL: kp_a0=1. If kp_dataout[0]=1, go to READ; otherwise stay.
  - READ: kp_a0=0. Capture kp_dataout[3:0] into the key register; go to CLR.
  - CLR: kp_a0=1, kp_readyclr=1 for exactly this cycle; go to EXEC.
  - EXEC: act on the key as listed below; go to POLL, or to HOLD on an accepted submit.
  - HOLD: out_valid=1. The keypad is not polled. On out_ack=1, go to POLL and clear the entry.
- kp_a0 is 1 in every state except READ. kp_readyclr is 1 only in CLR.
- Key handling in EXEC:
  - Digit d with count < MAX_DIGITS: value <= value*10 + d; entry_bcd <= {entry_bcd[11:0], d}; count++.
  - Digit with count = MAX_DIGITS: err pulse; entry unchanged.
  - A-D: cmd <= key - 0x9, giving 1..4. The last command key pressed wins. Count unchanged.
  - `*`: value, entry_bcd, count and cmd are cleared to 0.
  - `#` with count >= 1: out_value, out_cmd and out_ndigits are loaded from the entry; go to HOLD.
  - `#` with count = 0: err pulse; stay in the entry, go to POLL.
- Arithmetic: value*10 + d is computed at 14 bits. With MAX_DIGITS <= 4 it never overflows (9999 max).
- entry_bcd keeps showing the submitted digits throughout HOLD. It is cleared on the cycle of the ack.
- out_value, out_cmd and out_ndigits are stable for the whole time out_valid is high. After the ack they keep their last value.

## Timing
- Reset values (all outputs): kp_a0=1, kp_readyclr=0, out_valid=0, out_value=0, out_cmd=0, out_ndigits=0, entry_bcd=0, err=0; state POLL; internal value, count and cmd = 0.
- Latency from ready being seen in POLL (cycle N):
  - READ at N+1;
  - kp_readyclr high at N+2;
  - EXEC at N+3, with entry_bcd, err, out_valid and the out_* fields registered out at N+4;
  - back in POLL at N+4.
- err is high for exactly one cycle, the cycle after EXEC.
- Handshake: out_valid rises the cycle after EXEC of an accepted `#`. It falls the cycle after out_ack is sampled high. out_ack asserted while out_valid=0 is ignored.
- Keys pressed during HOLD stay latched in the scanner. Only the most recent key code survives, because the scanner overwrites it. That key is processed after the ack, which is the required behaviour.
- A scanner ready edge that coincides with CLR takes priority inside the scanner and is read on the next POLL. No key is lost.
- Reset in any state returns to POLL immediately. A ready flag left set in the scanner (readyclr not yet issued) is read again after reset; that is expected.

## Test plan
- Keys 1,2,3,`#` -> out_valid=1, out_value=123, out_ndigits=3, out_cmd=0, entry_bcd=0x0123. out_ack -> out_valid=0 and entry_bcd=0 on the next cycle.
- Keys 9,9,9,9,5 -> err pulse on the fifth key; entry_bcd=0x9999. Then `#` -> out_value=9999.
- Keys 4,B,7,C,`#` -> out_value=47, out_cmd=3, out_ndigits=2.
- Keys 5,`*`,`#` -> err pulse and no out_valid. Then 8,`#` -> out_value=8.
- Single key: check kp_a0=0 for exactly one cycle, then kp_readyclr=1 for exactly one cycle, with the N+1..N+4 timing above. Hold out_ack=0 for 50 cycles with a key press in between -> out_* stable and kp_a0 stays 1; after the ack, the pending key is processed.
- Assert rst in READ, and separately in HOLD -> all outputs return to their reset values the next cycle; the pending ready is re-read and processed.
